// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register file slice: default widths,
// clear-engine state encoding and the hardwired zero register address.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: masks output while the clear engine runs,
// hardwires the zero register, forwards a same-cycle writeback and
// reports the pending (hazard) bit of the addressed register.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_pend,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  // Priority: clearing, zero register, writeback bypass, stored entry.
  always_comb begin
    rdata = '0;
    busy  = 1'b0;
    if (!ready) begin
      rdata = '0;
      busy  = 1'b0;
    end else if (ZERO_REG && (raddr == ADDR_W'(ZERO_ADDR))) begin
      rdata = '0;
      busy  = 1'b0;
    end else if (BYPASS && we && (waddr == raddr)) begin
      rdata = wdata;
      busy  = pend_set && (pend_addr == raddr);
    end else begin
      rdata = arr_data;
      busy  = arr_pend;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// ID-stage register file with two async read ports, one sync write port,
// a per-register pending scoreboard and a sequential clear engine that
// zeroes every entry after reset or on a clr_req pulse.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_ok;
  logic              set_ok;
  logic              last_cnt;

  assign ready    = (state == ST_IDLE);
  assign last_cnt = (cnt == ADDR_W'(DEPTH - 1));
  assign wr_ok    = ready && we &&
                    !(ZERO_REG && (waddr == ADDR_W'(ZERO_ADDR)));
  assign set_ok   = ready && pend_set &&
                    !(ZERO_REG && (pend_addr == ADDR_W'(ZERO_ADDR)));

  // Clear engine: walk cnt over every entry, then idle until clr_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      if (last_cnt) begin
        state <= ST_IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (clr_req) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end
  end

  // Array is only zeroed by the clear engine, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Scoreboard: writeback clears a bit, issue sets it; set wins on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (state == ST_CLEAR) begin
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_ok) begin
        pend[waddr] <= 1'b0;
      end
      if (set_ok) begin
        pend[pend_addr] <= 1'b1;
      end
    end
  end

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_a (
    .ready     (ready),
    .raddr     (raddr_a),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .arr_data  (mem[raddr_a]),
    .arr_pend  (pend[raddr_a]),
    .rdata     (rdata_a),
    .busy      (busy_a)
  );

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_b (
    .ready     (ready),
    .raddr     (raddr_b),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .arr_data  (mem[raddr_b]),
    .arr_pend  (pend[raddr_b]),
    .rdata     (rdata_b),
    .busy      (busy_b)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against an
// array-based model of the register file.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        ready;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        pend_set = 1'b0;
  logic [4:0]  pend_addr = '0;
  logic [4:0]  raddr_a = '0;
  logic [31:0] rdata_a;
  logic        busy_a;
  logic [4:0]  raddr_b = '0;
  logic [31:0] rdata_b;
  logic        busy_b;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference state: data and pending bits, plus cycles left in a clear.
  logic [31:0] memM [32];
  bit          pendM [32];
  int          clearLeft = 32;

  regfile_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .ready     (ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .raddr_a   (raddr_a),
    .rdata_a   (rdata_a),
    .busy_a    (busy_a),
    .raddr_b   (raddr_b),
    .rdata_b   (rdata_b),
    .busy_b    (busy_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Outputs a port must show given the model state and current inputs.
  function automatic void modelRead(input logic [4:0] ra, output logic [31:0] d,
                                    output logic b);
    d = '0;
    b = 1'b0;
    if (!rst_n || clearLeft != 0) begin
      d = '0;
      b = 1'b0;
    end else if (ra == 5'd0) begin
      d = '0;
      b = 1'b0;
    end else if (we && waddr == ra) begin
      d = wdata;
      b = pend_set && (pend_addr == ra);
    end else begin
      d = memM[ra];
      b = pendM[ra];
    end
  endfunction

  // Model update: a clear is observed only as "ready low for 32 cycles,
  // then everything zero", so the arrays are wiped when it starts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clearLeft = 32;
      for (int i = 0; i < 32; i++) begin
        memM[i]  = '0;
        pendM[i] = 1'b0;
      end
    end else if (clearLeft != 0) begin
      clearLeft = clearLeft - 1;
    end else begin
      if (we && waddr != 5'd0) begin
        memM[waddr]  = wdata;
        pendM[waddr] = 1'b0;
      end
      if (pend_set && pend_addr != 5'd0) begin
        pendM[pend_addr] = 1'b1;
      end
      if (clr_req) begin
        clearLeft = 32;
        for (int i = 0; i < 32; i++) begin
          memM[i]  = '0;
          pendM[i] = 1'b0;
        end
      end
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    logic [31:0] ed;
    logic        eb;
    if (checkEn) begin
      checkOutput("ready", {31'd0, ready}, {31'd0, (rst_n && clearLeft == 0)});
      modelRead(raddr_a, ed, eb);
      checkOutput("rdata_a", rdata_a, ed);
      checkOutput("busy_a", {31'd0, busy_a}, {31'd0, eb});
      modelRead(raddr_b, ed, eb);
      checkOutput("rdata_b", rdata_b, ed);
      checkOutput("busy_b", {31'd0, busy_b}, {31'd0, eb});
    end
  end

  task automatic applyStimulus(input logic weV, input logic [4:0] waV,
                               input logic [31:0] wdV, input logic psV,
                               input logic [4:0] paV, input logic [4:0] raV,
                               input logic [4:0] rbV, input logic crV);
    we        = weV;
    waddr     = waV;
    wdata     = wdV;
    pend_set  = psV;
    pend_addr = paV;
    raddr_a   = raV;
    raddr_b   = rbV;
    clr_req   = crV;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitClearDone(input string name);
    for (int k = 0; k < 31; k++) begin
      nextCycle();
      checkOutput({name, "_ready_low"}, {31'd0, ready}, 32'd0);
    end
    nextCycle();
    checkOutput({name, "_ready_high"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic sweepZero(input string name);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(31 - i), 1'b0);
      #2;
      checkOutput({name, "_rdata_a"}, rdata_a, 32'd0);
      checkOutput({name, "_busy_a"}, {31'd0, busy_a}, 32'd0);
      nextCycle();
    end
  endtask

  initial begin
    // Reset and initial clear.
    nextCycle();
    nextCycle();
    checkEn = 1'b1;
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    waitClearDone("init");
    sweepZero("init");

    // Bypass then stored read.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    #2;
    checkOutput("bypass_a", rdata_a, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
    #2;
    checkOutput("stored_a", rdata_a, 32'hDEADBEEF);
    nextCycle();

    // Zero register ignores writes and pending marks.
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    checkOutput("zero_same_d", rdata_a, 32'd0);
    checkOutput("zero_same_b", {31'd0, busy_a}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    checkOutput("zero_after_d", rdata_a, 32'd0);
    checkOutput("zero_after_b", {31'd0, busy_a}, 32'd0);
    nextCycle();

    // Scoreboard set, clear by writeback, simultaneous set and write.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    #2;
    checkOutput("pend7_busy", {31'd0, busy_b}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd7, 32'd9, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    #2;
    checkOutput("wb7_byp_busy", {31'd0, busy_b}, 32'd0);
    checkOutput("wb7_byp_data", rdata_b, 32'd9);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    #2;
    checkOutput("wb7_busy", {31'd0, busy_b}, 32'd0);
    checkOutput("wb7_data", rdata_b, 32'd9);
    nextCycle();
    applyStimulus(1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0);
    #2;
    checkOutput("tie7_byp_busy", {31'd0, busy_b}, 32'd1);
    checkOutput("tie7_byp_data", rdata_b, 32'h55);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    #2;
    checkOutput("tie7_busy", {31'd0, busy_b}, 32'd1);
    checkOutput("tie7_data", rdata_b, 32'h55);
    nextCycle();

    // Fill, mark r3 pending, then request a clear with ignored writes.
    for (int r = 1; r < 32; r++) begin
      applyStimulus(1'b1, 5'(r), 32'(r), 1'b0, 5'd0, 5'(r), 5'd0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd12, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd12, 1'b1);
    #2;
    checkOutput("fill_busy3", {31'd0, busy_a}, 32'd1);
    checkOutput("fill_r12", rdata_b, 32'd12);
    checkOutput("clr_req_ready", {31'd0, ready}, 32'd1);
    nextCycle();
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1'b1, 5'd4, 32'hFFFF, 1'b1, 5'd4, 5'd4, 5'd3, 1'b0);
      #2;
      checkOutput("clr_ready_low", {31'd0, ready}, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4, 1'b0);
    #2;
    checkOutput("clr_ready_high", {31'd0, ready}, 32'd1);
    checkOutput("clr_busy3", {31'd0, busy_a}, 32'd0);
    checkOutput("clr_r4", rdata_b, 32'd0);
    nextCycle();
    sweepZero("clr");

    // Reset asserted ten cycles into a clear.
    applyStimulus(1'b1, 5'd9, 32'hAB, 1'b0, 5'd0, 5'd9, 5'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
    for (int k = 0; k < 10; k++) nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midclr_rst_ready", {31'd0, ready}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    waitClearDone("midclr");
    sweepZero("midclr");

    // Randomized traffic, checked each cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom,
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)),
                    ($urandom_range(0, 199) == 0));
      nextCycle();
    end

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
